// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_sel_e;

    // Read data returned to the owner when the memory never answers.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the arbiter and the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  instr_req_i;
    logic [ADDR_W-1:0]     instr_addr_i;
    logic                  instr_gnt_o;
    logic                  instr_rvalid_o;

    logic                  data_req_i;
    logic                  data_we_i;
    logic [DATA_W/8-1:0]   data_be_i;
    logic [ADDR_W-1:0]     data_addr_i;
    logic [DATA_W-1:0]     data_wdata_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;

    logic [DATA_W-1:0]     rdata_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [DATA_W/8-1:0]   mem_be_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_W-1:0]     mem_rdata_i;

    logic                  err_o;

    // Arbiter side.
    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o, rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, err_o
    );

    // Requester/memory side.
    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o, rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, err_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way tie-break: a lone requester wins, a tie goes to whoever was not served last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic     req_instr,
    input  logic     req_data,
    input  req_sel_e rr,
    output req_sel_e winner
);

    always_comb begin
        winner = REQ_DATA;
        if (req_instr && req_data) begin
            winner = (rr == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
        end else if (req_instr) begin
            winner = REQ_INSTR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one transaction in flight, with a response watchdog.
//
//   state   | meaning
//   IDLE    | no transaction; pick an owner if anyone requests
//   REQ     | request presented to memory, waiting for mem_gnt_i
//   RESP    | granted, waiting for mem_rvalid_i or watchdog expiry
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e        state_q, state_d;
    req_sel_e          sel_q, rr_q, winner;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              any_req;
    logic              expired;

    assign any_req = bus.instr_req_i | bus.data_req_i;
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    rr_arb2 u_rr_arb2 (
        .req_instr (bus.instr_req_i),
        .req_data  (bus.data_req_i),
        .rr        (rr_q),
        .winner    (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req)                      state_d = ST_REQ;
            ST_REQ:  if (bus.mem_gnt_i)                state_d = ST_RESP;
            ST_RESP: if (bus.mem_rvalid_i || expired)  state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    // Request fields are captured at arbitration so they stay frozen in REQ
    // even if the requester changes or drops its inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q   <= REQ_DATA;
            rr_q    <= REQ_INSTR;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        sel_q <= winner;
                        if (winner == REQ_DATA) begin
                            we_q    <= bus.data_we_i;
                            be_q    <= bus.data_be_i;
                            addr_q  <= bus.data_addr_i;
                            wdata_q <= bus.data_wdata_i;
                        end else begin
                            we_q    <= 1'b0;
                            be_q    <= '1;
                            addr_q  <= bus.instr_addr_i;
                            wdata_q <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.mem_gnt_i) begin
                        rr_q  <= sel_q;
                        cnt_q <= '0;
                    end
                end
                ST_RESP: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_req_o      = 1'b0;
        bus.mem_we_o       = 1'b0;
        bus.mem_be_o       = '0;
        bus.mem_addr_o     = '0;
        bus.mem_wdata_o    = '0;
        bus.instr_gnt_o    = 1'b0;
        bus.data_gnt_o     = 1'b0;
        bus.instr_rvalid_o = 1'b0;
        bus.data_rvalid_o  = 1'b0;
        bus.rdata_o        = '0;
        bus.err_o          = 1'b0;
        case (state_q)
            ST_REQ: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = we_q;
                bus.mem_be_o    = be_q;
                bus.mem_addr_o  = addr_q;
                bus.mem_wdata_o = wdata_q;
                bus.instr_gnt_o = bus.mem_gnt_i && (sel_q == REQ_INSTR);
                bus.data_gnt_o  = bus.mem_gnt_i && (sel_q == REQ_DATA);
            end
            ST_RESP: begin
                // A real response arriving on the expiry cycle takes priority.
                if (bus.mem_rvalid_i || expired) begin
                    bus.instr_rvalid_o = (sel_q == REQ_INSTR);
                    bus.data_rvalid_o  = (sel_q == REQ_DATA);
                    bus.rdata_o        = bus.mem_rvalid_i ? bus.mem_rdata_i
                                                          : DATA_W'(TIMEOUT_RDATA);
                    bus.err_o          = ~bus.mem_rvalid_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level ownership model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int TO     = 16;

    logic clk;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   last_data;   // model: 1 when the last served requester was load/store

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic              gi;
        logic              gd;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              changed;
        logic              ri;
        logic              rd;
        logic [DATA_W-1:0] rdata;
        int                errs;
        int                rcyc;
    } obs_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [106:0] all_outs();
        return {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o,
                bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o,
                bus.rdata_o, bus.err_o};
    endfunction

    // Ownership rule: a lone requester wins; a tie goes to the one not served last.
    function automatic bit predict_data(bit pi, bit pd, bit last_d);
        if (pi && pd) return !last_d;
        return pd;
    endfunction

    task automatic clear_inputs();
        bus.instr_req_i  = 0; bus.instr_addr_i = '0;
        bus.data_req_i   = 0; bus.data_we_i    = 0; bus.data_be_i = '0;
        bus.data_addr_i  = '0; bus.data_wdata_i = '0;
        bus.mem_gnt_i    = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
    endtask

    task automatic apply_reset();
        rst = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        last_data = 0;
    endtask

    // Plays the memory: grant after gnt_wait REQ cycles, respond after rsp_wait
    // RESP cycles (negative = never), drop the granted requester's req.
    task automatic handshake(input int gnt_wait, input int rsp_wait,
                             input logic [DATA_W-1:0] rd, input bit drop, output obs_t o);
        int n;
        o = '{default: 0};
        n = 0;
        @(negedge clk);
        while (!bus.mem_req_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mem_req_o) return;
        o.we = bus.mem_we_o; o.be = bus.mem_be_o;
        o.addr = bus.mem_addr_o; o.wdata = bus.mem_wdata_o;
        if (drop) begin
            bus.instr_req_i = 0;
            bus.data_req_i  = 0;
        end
        repeat (gnt_wait) begin
            @(negedge clk);
            if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o}
                !== {1'b1, o.we, o.be, o.addr, o.wdata}) o.changed = 1;
        end
        bus.mem_gnt_i = 1;
        #1;
        o.gi = bus.instr_gnt_o;
        o.gd = bus.data_gnt_o;
        @(posedge clk); #1;
        bus.mem_gnt_i = 0;
        if (o.gi) bus.instr_req_i = 0;
        if (o.gd) bus.data_req_i  = 0;
        for (int k = 0; k < TO + 4; k++) begin
            @(negedge clk);
            if (k == rsp_wait) begin
                bus.mem_rvalid_i = 1;
                bus.mem_rdata_i  = rd;
            end
            #1;
            if (bus.err_o) o.errs++;
            if (bus.instr_rvalid_o || bus.data_rvalid_o) begin
                o.ri = bus.instr_rvalid_o; o.rd = bus.data_rvalid_o;
                o.rdata = bus.rdata_o; o.rcyc = k + 1;
                @(posedge clk); #1;
                bus.mem_rvalid_i = 0;
                return;
            end
            @(posedge clk); #1;
            bus.mem_rvalid_i = 0;
        end
    endtask

    task automatic test_reset();
        rst = 0;
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h40;
        bus.data_req_i  = 1; bus.data_we_i = 1; bus.data_be_i = 4'hF;
        bus.data_addr_i = 32'h80; bus.data_wdata_i = 32'h55;
        bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1234_5678;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (all_outs() !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        clear_inputs();
        rst = 1;
        @(posedge clk); @(negedge clk);
        tests_run++;
        if (all_outs() !== '0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %h expected 0", all_outs());
        end
        last_data = 0;
    endtask

    task automatic test_single_instr();
        obs_t o;
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h100;
        handshake(0, 1, 32'h13, 0, o);
        tests_run++;
        if ({o.gi, o.gd} !== 2'b10) begin
            tests_failed++; $display("FAIL single_gnt: got %b expected 10", {o.gi, o.gd});
        end
        tests_run++;
        if ({o.we, o.be, o.addr} !== {1'b0, 4'hF, 32'h100}) begin
            tests_failed++; $display("FAIL single_fields: got %h expected %h", {o.we, o.be, o.addr}, {1'b0, 4'hF, 32'h100});
        end
        tests_run++;
        if ({o.ri, o.rd, o.rdata, o.rcyc} !== {2'b10, 32'h13, 32'd2}) begin
            tests_failed++; $display("FAIL single_resp: got rv=%b rdata=%h cyc=%0d expected rv=10 rdata=13 cyc=2", {o.ri, o.rd}, o.rdata, o.rcyc);
        end
        last_data = 0;
    endtask

    task automatic test_tie_rr();
        obs_t o;
        bit pi, pd, win;
        logic [DATA_W-1:0] rdv;
        logic [ADDR_W-1:0] ai, ad;
        apply_reset();
        pi = 1; pd = 1;
        ai = $urandom; ad = $urandom;
        bus.instr_req_i = 1; bus.instr_addr_i = ai;
        bus.data_req_i = 1; bus.data_addr_i = ad; bus.data_we_i = 0; bus.data_be_i = 4'hF;
        for (int it = 0; it < 6 && (pi || pd); it++) begin
            win = predict_data(pi, pd, last_data);
            rdv = $urandom;
            handshake($urandom_range(0, 2), $urandom_range(0, 2), rdv, 0, o);
            tests_run++;
            if ({o.gi, o.gd, o.addr} !== {!win, win, win ? ad : ai}) begin
                tests_failed++; $display("FAIL tie_owner[%0d]: got gnt=%b addr=%h expected data=%0d", it, {o.gi, o.gd}, o.addr, win);
            end
            tests_run++;
            if ({o.ri, o.rd, o.rdata} !== {!win, win, rdv}) begin
                tests_failed++; $display("FAIL tie_resp[%0d]: got rv=%b rdata=%h expected data=%0d rdata=%h", it, {o.ri, o.rd}, o.rdata, win, rdv);
            end
            last_data = win;
            if (win) pd = 0; else pi = 0;
            if (it < 3) begin
                if (win) begin ad = $urandom; bus.data_addr_i = ad; bus.data_req_i = 1; pd = 1; end
                else     begin ai = $urandom; bus.instr_addr_i = ai; bus.instr_req_i = 1; pi = 1; end
            end
        end
    endtask

    task automatic test_store_hold();
        obs_t o;
        bus.data_req_i = 1; bus.data_we_i = 1; bus.data_be_i = 4'h3;
        bus.data_addr_i = 32'h2000; bus.data_wdata_i = 32'hA5A5;
        handshake(4, 0, 32'h0, 0, o);
        tests_run++;
        if ({o.gi, o.gd, o.we, o.be, o.addr, o.wdata} !== {2'b01, 1'b1, 4'h3, 32'h2000, 32'hA5A5}) begin
            tests_failed++; $display("FAIL store_bundle: got gnt=%b we=%b be=%h addr=%h wdata=%h", {o.gi, o.gd}, o.we, o.be, o.addr, o.wdata);
        end
        tests_run++;
        if (o.changed !== 1'b0) begin
            tests_failed++; $display("FAIL store_stable: got changed=%b expected 0", o.changed);
        end
        tests_run++;
        if ({o.ri, o.rd} !== 2'b01) begin
            tests_failed++; $display("FAIL store_rvalid: got %b expected 01", {o.ri, o.rd});
        end
        last_data = 1;
    endtask

    task automatic test_drop_before_gnt();
        obs_t o;
        logic [ADDR_W-1:0] a;
        a = $urandom;
        bus.instr_req_i = 1; bus.instr_addr_i = a;
        handshake(3, 0, 32'h77, 1, o);
        tests_run++;
        if ({o.gi, o.gd, o.changed, o.addr} !== {2'b10, 1'b0, a}) begin
            tests_failed++; $display("FAIL drop_keep_req: got gnt=%b changed=%b addr=%h expected gnt=10 changed=0 addr=%h", {o.gi, o.gd}, o.changed, o.addr, a);
        end
        last_data = 0;
    endtask

    task automatic test_timeout();
        obs_t o;
        bus.data_req_i = 1; bus.data_we_i = 0; bus.data_be_i = 4'hF; bus.data_addr_i = 32'h300;
        handshake(0, -1, 32'h0, 0, o);
        tests_run++;
        if ({o.ri, o.rd, o.rdata} !== {2'b01, 32'hDEADBEEF}) begin
            tests_failed++; $display("FAIL timeout_resp: got rv=%b rdata=%h expected rv=01 rdata=deadbeef", {o.ri, o.rd}, o.rdata);
        end
        tests_run++;
        if (o.errs !== 1 || o.rcyc !== TO) begin
            tests_failed++; $display("FAIL timeout_err: got errs=%0d cyc=%0d expected errs=1 cyc=%0d", o.errs, o.rcyc, TO);
        end
        @(negedge clk);
        tests_run++;
        if ({bus.err_o, bus.data_rvalid_o} !== 2'b00) begin
            tests_failed++; $display("FAIL timeout_pulse: got err/rv=%b expected 00", {bus.err_o, bus.data_rvalid_o});
        end
        @(posedge clk); #1;
        last_data = 1;
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h404;
        handshake(0, 0, 32'hCAFE, 0, o);
        tests_run++;
        if ({o.gi, o.ri, o.rdata, o.errs} !== {2'b11, 32'hCAFE, 32'd0}) begin
            tests_failed++; $display("FAIL after_timeout: got gnt=%b rv=%b rdata=%h errs=%0d", o.gi, o.ri, o.rdata, o.errs);
        end
        last_data = 0;
    endtask

    task automatic test_rvalid_at_expiry();
        obs_t o;
        bus.data_req_i = 1; bus.data_we_i = 0; bus.data_be_i = 4'hF; bus.data_addr_i = 32'h500;
        handshake(1, TO - 1, 32'h600D, 0, o);
        tests_run++;
        if ({o.rd, o.rdata, o.errs, o.rcyc} !== {1'b1, 32'h600D, 32'd0, TO}) begin
            tests_failed++; $display("FAIL rvalid_wins: got rv=%b rdata=%h errs=%0d cyc=%0d expected rv=1 rdata=600d errs=0 cyc=%0d", o.rd, o.rdata, o.errs, o.rcyc, TO);
        end
        last_data = 1;
    endtask

    task automatic test_rvalid_ignored();
        obs_t o;
        int n;
        @(negedge clk);
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hBAD;
        #1;
        tests_run++;
        if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.err_o} !== 3'b000) begin
            tests_failed++; $display("FAIL ignore_idle: got %b expected 000", {bus.instr_rvalid_o, bus.data_rvalid_o, bus.err_o});
        end
        @(posedge clk); #1;
        bus.mem_rvalid_i = 0;
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h700;
        n = 0;
        @(negedge clk);
        while (!bus.mem_req_o && n < 8) begin @(negedge clk); n++; end
        bus.mem_rvalid_i = 1;
        #1;
        tests_run++;
        if ({bus.mem_req_o, bus.instr_rvalid_o, bus.data_rvalid_o, bus.err_o} !== 4'b1000) begin
            tests_failed++; $display("FAIL ignore_req: got %b expected 1000", {bus.mem_req_o, bus.instr_rvalid_o, bus.data_rvalid_o, bus.err_o});
        end
        @(posedge clk); #1;
        bus.mem_rvalid_i = 0;
        handshake(0, 0, 32'h71, 0, o);
        tests_run++;
        if ({o.gi, o.ri, o.rdata} !== {2'b11, 32'h71}) begin
            tests_failed++; $display("FAIL ignore_then_txn: got gnt=%b rv=%b rdata=%h", o.gi, o.ri, o.rdata);
        end
        last_data = 0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int n;
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h800;
        n = 0;
        @(negedge clk);
        while (!bus.mem_req_o && n < 8) begin @(negedge clk); n++; end
        tests_run++;
        if (bus.mem_req_o !== 1'b1) begin
            tests_failed++; $display("FAIL rstmid_req: got %b expected 1", bus.mem_req_o);
        end
        bus.mem_gnt_i = 1;
        @(posedge clk); #1;
        bus.mem_gnt_i = 0; bus.instr_req_i = 0;
        @(negedge clk);
        rst = 0;
        #1;
        tests_run++;
        if (all_outs() !== '0) begin
            tests_failed++; $display("FAIL rstmid_async: got %h expected 0", all_outs());
        end
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1A7E;
        #1;
        tests_run++;
        if (all_outs() !== '0) begin
            tests_failed++; $display("FAIL rstmid_late_rvalid: got %h expected 0", all_outs());
        end
        @(posedge clk); #1;
        bus.mem_rvalid_i = 0;
        last_data = 0;
        bus.instr_req_i = 1; bus.instr_addr_i = 32'h900;
        bus.data_req_i = 1; bus.data_addr_i = 32'hA00; bus.data_we_i = 0; bus.data_be_i = 4'hF;
        handshake(0, 0, 32'h1, 0, o);
        tests_run++;
        if ({o.gi, o.gd} !== 2'b01) begin
            tests_failed++; $display("FAIL rstmid_tie_data_first: got %b expected 01", {o.gi, o.gd});
        end
        handshake(0, 0, 32'h2, 0, o);
        last_data = 0;
    endtask

    task automatic test_random();
        obs_t o;
        bit pi, pd, win;
        logic [1:0] pat;
        logic [ADDR_W-1:0] ai, ad;
        logic [DATA_W-1:0] wd, rdv;
        logic we;
        logic [BE_W-1:0] be;
        for (int r = 0; r < 12; r++) begin
            pat = 2'($urandom_range(1, 3));
            pi = pat[0]; pd = pat[1];
            ai = $urandom; ad = $urandom; wd = $urandom; we = 1'($urandom); be = 4'($urandom);
            bus.instr_addr_i = ai; bus.data_addr_i = ad; bus.data_wdata_i = wd;
            bus.data_we_i = we; bus.data_be_i = be;
            bus.instr_req_i = pi; bus.data_req_i = pd;
            while (pi || pd) begin
                win = predict_data(pi, pd, last_data);
                rdv = $urandom;
                handshake($urandom_range(0, 3), $urandom_range(0, 3), rdv, 0, o);
                tests_run++;
                if ({o.gi, o.gd, o.we, o.be, o.addr} !== (win ? {2'b01, we, be, ad} : {2'b10, 1'b0, 4'hF, ai})) begin
                    tests_failed++; $display("FAIL rand_req[%0d]: got gnt=%b we=%b be=%h addr=%h expected data=%0d", r, {o.gi, o.gd}, o.we, o.be, o.addr, win);
                end
                if (win) begin
                    tests_run++;
                    if (o.wdata !== wd) begin
                        tests_failed++; $display("FAIL rand_wdata[%0d]: got %h expected %h", r, o.wdata, wd);
                    end
                end
                tests_run++;
                if ({o.ri, o.rd, o.rdata, o.errs, o.changed} !== {!win, win, rdv, 32'd0, 1'b0}) begin
                    tests_failed++; $display("FAIL rand_resp[%0d]: got rv=%b rdata=%h errs=%0d changed=%b expected rdata=%h", r, {o.ri, o.rd}, o.rdata, o.errs, o.changed, rdv);
                end
                last_data = win;
                if (win) pd = 0; else pi = 0;
            end
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_single_instr();
        test_tie_rr();
        test_store_hold();
        test_drop_before_gnt();
        test_timeout();
        test_rvalid_at_expiry();
        test_rvalid_ignored();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
